// File: rtl/reg_wb_sched_pkg.sv
// Shared types and constants for the register-file write-back scheduler.
// The optional forwarding path is enabled by the REG_WB_BYPASS_EN macro.
package reg_wb_sched_pkg;

  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = $clog2(NREG);

  // Write-back source identity; also the encoding of the arbiter's last_grant.
  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       reg_data_t;

  // Source read or destination write collides with an outstanding write.
  // x0 is hardwired and can never be pending.
  function automatic logic pending_hit(logic en, reg_addr_t addr, logic [NREG-1:0] pend);
    return en && (addr != '0) && pend[addr];
  endfunction

endpackage

// File: rtl/reg_wb_sched_if.sv
// Bundle of the decode/issue, ALU/LSU write-back and RF write-port signals.
// With REG_WB_BYPASS_EN defined the forwarding outputs are added.
interface reg_wb_sched_if;
  import reg_wb_sched_pkg::*;

  // Decode / issue
  logic      issue_valid;
  reg_addr_t issue_rd;
  logic      issue_rd_we;
  reg_addr_t issue_rs1;
  logic      issue_use1;
  reg_addr_t issue_rs2;
  logic      issue_use2;
  logic      issue_stall;

  // Write-back sources
  logic      alu_valid;
  logic      alu_ready;
  reg_addr_t alu_addr;
  reg_data_t alu_value;
  logic      lsu_valid;
  logic      lsu_ready;
  reg_addr_t lsu_addr;
  reg_data_t lsu_value;

  // Register-file write port
  logic      write_en;
  reg_addr_t write_addr;
  reg_data_t write_value;

`ifdef REG_WB_BYPASS_EN
  logic      fwd1_hit;
  logic      fwd2_hit;
  reg_data_t fwd_data;

  modport master (
    output issue_valid, issue_rd, issue_rd_we, issue_rs1, issue_use1, issue_rs2, issue_use2,
    output alu_valid, alu_addr, alu_value, lsu_valid, lsu_addr, lsu_value,
    input  issue_stall, alu_ready, lsu_ready, write_en, write_addr, write_value,
    input  fwd1_hit, fwd2_hit, fwd_data
  );

  modport slave (
    input  issue_valid, issue_rd, issue_rd_we, issue_rs1, issue_use1, issue_rs2, issue_use2,
    input  alu_valid, alu_addr, alu_value, lsu_valid, lsu_addr, lsu_value,
    output issue_stall, alu_ready, lsu_ready, write_en, write_addr, write_value,
    output fwd1_hit, fwd2_hit, fwd_data
  );
`else
  modport master (
    output issue_valid, issue_rd, issue_rd_we, issue_rs1, issue_use1, issue_rs2, issue_use2,
    output alu_valid, alu_addr, alu_value, lsu_valid, lsu_addr, lsu_value,
    input  issue_stall, alu_ready, lsu_ready, write_en, write_addr, write_value
  );

  modport slave (
    input  issue_valid, issue_rd, issue_rd_we, issue_rs1, issue_use1, issue_rs2, issue_use2,
    input  alu_valid, alu_addr, alu_value, lsu_valid, lsu_addr, lsu_value,
    output issue_stall, alu_ready, lsu_ready, write_en, write_addr, write_value
  );
`endif

endinterface

// File: rtl/reg_wb_sched_arb.sv
// Two-way round-robin arbiter: req[0]=ALU, req[1]=LSU. A lone request is
// always granted; on a tie the source that did not win last time is granted.
module wb_rr_arb2
  import reg_wb_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_e last_grant;

  // Combinational grant from the request pair and the last winner.
  always_comb begin
    // NOTE: gnt gets a default before the case so no branch leaves it unassigned (no latch).
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == WB_SRC_LSU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember the winner of every grant; reset to LSU so the first tie goes to ALU.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
    if (reset)
      last_grant <= WB_SRC_LSU;
    else if (gnt[1])
      last_grant <= WB_SRC_LSU;
    else if (gnt[0])
      last_grant <= WB_SRC_ALU;
  end

endmodule

// File: rtl/reg_wb_sched.sv
// Write-back scheduler and hazard scoreboard for the 32x32 register file.
// Arbitrates ALU/LSU onto the single RF write port (1-cycle registered
// latency) and stalls decode on RAW/WAW against pending destinations.
// Optional feature: define REG_WB_BYPASS_EN to forward the in-flight write
// to decode instead of stalling on it.
module reg_wb_sched
  import reg_wb_sched_pkg::*;
(
  input logic          clk,
  input logic          reset,
  reg_wb_sched_if.slave bus
);

  logic [1:0]     req;
  logic [1:0]     gnt;
  logic           xfer;
  reg_addr_t      xfer_addr;
  reg_data_t      xfer_value;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  logic           hazard;
  logic           accept;

  // Sources see no ready while reset is high, so nothing is transferred.
  assign req = reset ? 2'b00 : {bus.lsu_valid, bus.alu_valid};

  wb_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  assign bus.alu_ready = gnt[0];
  assign bus.lsu_ready = gnt[1];

  assign xfer       = |gnt;
  assign xfer_addr  = gnt[1] ? bus.lsu_addr  : bus.alu_addr;
  assign xfer_value = gnt[1] ? bus.lsu_value : bus.alu_value;

`ifdef REG_WB_BYPASS_EN
  logic byp1, byp2, byp_rd;

  // A match against the write retiring this cycle is forwarded, not stalled.
  assign byp1   = bus.write_en && (bus.write_addr == bus.issue_rs1);
  assign byp2   = bus.write_en && (bus.write_addr == bus.issue_rs2);
  assign byp_rd = bus.write_en && (bus.write_addr == bus.issue_rd);

  assign hazard = (pending_hit(bus.issue_use1,  bus.issue_rs1, pending) && !byp1) ||
                  (pending_hit(bus.issue_use2,  bus.issue_rs2, pending) && !byp2) ||
                  (pending_hit(bus.issue_rd_we, bus.issue_rd,  pending) && !byp_rd);

  assign bus.fwd1_hit = bus.issue_use1 && byp1;
  assign bus.fwd2_hit = bus.issue_use2 && byp2;
  assign bus.fwd_data = bus.write_value;
`else
  // Stall is evaluated against pending before this edge's clear.
  assign hazard = pending_hit(bus.issue_use1,  bus.issue_rs1, pending) ||
                  pending_hit(bus.issue_use2,  bus.issue_rs2, pending) ||
                  pending_hit(bus.issue_rd_we, bus.issue_rd,  pending);
`endif

  assign bus.issue_stall = reset || (bus.issue_valid && hazard);
  assign accept          = bus.issue_valid && !bus.issue_stall;

  // Next scoreboard: clear the retiring write, then set the accepted destination (set wins).
  always_comb begin
    pending_nxt = pending;
    if (bus.write_en)
      pending_nxt[bus.write_addr] = 1'b0;
    if (accept && bus.issue_rd_we && (bus.issue_rd != '0))
      pending_nxt[bus.issue_rd] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    // NOTE: pending is a flop vector, not a RAM, so it takes a reset; the RF array itself needs none.
    if (reset)
      pending <= '0;
    else
      pending <= pending_nxt;
  end

  // RF write-port registers; x0 transfers are accepted but never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.write_en    <= 1'b0;
      bus.write_addr  <= '0;
      bus.write_value <= '0;
    end else begin
      bus.write_en <= xfer && (xfer_addr != '0);
      if (xfer && (xfer_addr != '0)) begin
        bus.write_addr  <= xfer_addr;
        bus.write_value <= xfer_value;
      end
    end
  end

endmodule
